// File: rtl/pe_noc_pkg.sv
// Shared NoC packet definitions for the PE array: field positions, packet types,
// node addresses and a header builder.
package pe_noc_pkg;

    localparam int ADDR_W   = 4;
    localparam int DEST_MSB = 63;
    localparam int DEST_LSB = 60;
    localparam int SRC_MSB  = 59;
    localparam int SRC_LSB  = 56;
    localparam int TYPE_MSB = 55;
    localparam int TYPE_LSB = 54;
    localparam int HDR_W    = 2 * ADDR_W + 2;

    typedef enum logic [1:0] {
        PKT_IFMAP  = 2'b00,
        PKT_FILTER = 2'b01,
        PKT_PSUM   = 2'b10,
        PKT_OFMAP  = 2'b11
    } pkt_type_t;

    localparam logic [ADDR_W-1:0] PE0_ADDR   = 4'b0001;
    localparam logic [ADDR_W-1:0] PE1_ADDR   = 4'b0101;
    localparam logic [ADDR_W-1:0] PE2_ADDR   = 4'b0011;
    localparam logic [ADDR_W-1:0] PE3_ADDR   = 4'b0111;
    localparam logic [ADDR_W-1:0] PE4_ADDR   = 4'b1100;
    localparam logic [ADDR_W-1:0] ADDER_ADDR = 4'b0010;
    localparam logic [ADDR_W-1:0] SINK_ADDR  = 4'b1000;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_ACK     = 2'b01,
        ST_RESULT  = 2'b10
    } adder_state_t;

    function automatic logic [HDR_W-1:0] build_header(
        input logic [ADDR_W-1:0] dest,
        input logic [ADDR_W-1:0] src,
        input pkt_type_t         ptype
    );
        return {dest, src, ptype};
    endfunction

endpackage

// File: rtl/pe_slot_decoder.sv
// Maps a PE source address onto its one-hot psum slot; hit is low for any
// address that is not one of the PEs feeding this adder.
module pe_slot_decoder
    import pe_noc_pkg::*;
#(
    parameter int NUM_PE = 5
) (
    input  logic [ADDR_W-1:0] src,
    output logic [NUM_PE-1:0] slot,
    output logic              hit
);

    always_comb begin
        slot = '0;
        hit  = 1'b1;
        unique case (src)
            PE0_ADDR: slot = NUM_PE'(1);
            PE1_ADDR: slot = NUM_PE'(1) << 1;
            PE2_ADDR: slot = NUM_PE'(1) << 2;
            PE3_ADDR: slot = NUM_PE'(1) << 3;
            PE4_ADDR: slot = NUM_PE'(1) << 4;
            default:  hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/psum_adder_node.sv
// Psum adder node: credits each PE psum, sums one psum per PE for an output
// position and sends the total to the ofmap sink.
module psum_adder_node
    import pe_noc_pkg::*;
#(
    parameter int                PACKET_WIDTH   = 64,
    parameter int                ADDR_WIDTH     = 4,
    parameter int                PSUM_WIDTH     = 13,
    parameter int                SUM_WIDTH      = 16,
    parameter int                NUM_PE         = 5,
    parameter int                ROUNDS_PER_ROW = 21,
    parameter logic [ADDR_W-1:0] NODE_ADDRESS   = ADDER_ADDR,
    parameter logic [ADDR_W-1:0] SINK_ADDRESS   = SINK_ADDR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PACKET_WIDTH-1:0] pkt_in_data,
    input  logic                    pkt_in_valid,
    output logic                    pkt_in_ready,
    output logic [PACKET_WIDTH-1:0] pkt_out_data,
    output logic                    pkt_out_valid,
    input  logic                    pkt_out_ready,
    output logic                    err_misroute,
    output logic                    err_dup,
    output logic [4:0]              round_idx
);

    generate
        if (SUM_WIDTH < PSUM_WIDTH + 3) begin : g_sum_width_check
            $error("psum_adder_node: SUM_WIDTH must be at least PSUM_WIDTH+3");
        end
    endgenerate

    adder_state_t            state_q, state_d;
    logic [NUM_PE-1:0]       mask_q, mask_d;
    logic [SUM_WIDTH-1:0]    acc_q, acc_d;
    logic [4:0]              round_q, round_d;
    logic [PACKET_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    misroute_q, misroute_d;
    logic                    dup_q, dup_d;
    logic                    live_q;

    logic [ADDR_WIDTH-1:0]   in_dest;
    logic [ADDR_WIDTH-1:0]   in_src;
    logic [1:0]              in_type;
    logic [PSUM_WIDTH-1:0]   in_psum;
    logic [NUM_PE-1:0]       src_slot;
    logic                    src_hit;
    logic                    accept;
    logic                    pkt_ok;
    logic                    is_dup;
    logic                    mask_full;
    logic                    out_fire;
    logic [PACKET_WIDTH-1:0] credit_pkt;
    logic [PACKET_WIDTH-1:0] result_pkt;
    logic                    unused_payload;

    assign in_dest        = pkt_in_data[DEST_MSB:DEST_LSB];
    assign in_src         = pkt_in_data[SRC_MSB:SRC_LSB];
    assign in_type        = pkt_in_data[TYPE_MSB:TYPE_LSB];
    assign in_psum        = pkt_in_data[PSUM_WIDTH-1:0];
    assign unused_payload = ^pkt_in_data[TYPE_LSB-1:PSUM_WIDTH];

    pe_slot_decoder #(
        .NUM_PE (NUM_PE)
    ) u_slot_decoder (
        .src  (in_src),
        .slot (src_slot),
        .hit  (src_hit)
    );

    // live_q keeps the input closed until the first edge after reset release.
    assign pkt_in_ready = live_q && (state_q == ST_COLLECT);
    assign accept       = pkt_in_valid && pkt_in_ready;
    assign pkt_ok       = (in_dest == NODE_ADDRESS) && (in_type == 2'(PKT_PSUM)) && src_hit;
    assign is_dup       = |(mask_q & src_slot);
    assign mask_full    = &mask_q;
    assign out_fire     = out_valid_q && pkt_out_ready;

    assign credit_pkt = {build_header(in_src, NODE_ADDRESS, PKT_PSUM),
                         {(PACKET_WIDTH - HDR_W){1'b0}}};

    always_comb begin
        result_pkt = '0;
        result_pkt[PACKET_WIDTH-1 -: HDR_W] = build_header(SINK_ADDRESS, NODE_ADDRESS, PKT_OFMAP);
        result_pkt[SUM_WIDTH +: 5]          = round_q;
        result_pkt[SUM_WIDTH-1:0]           = acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            mask_q      <= '0;
            acc_q       <= '0;
            round_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            misroute_q  <= 1'b0;
            dup_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            acc_q       <= acc_d;
            round_q     <= round_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            misroute_q  <= misroute_d;
            dup_q       <= dup_d;
            live_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_COLLECT: if (accept && pkt_ok) state_d = ST_ACK;
            ST_ACK:     if (out_fire) state_d = mask_full ? ST_RESULT : ST_COLLECT;
            ST_RESULT:  if (out_fire) state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // A duplicate still earns a credit so the sending PE never deadlocks.
    always_comb begin
        mask_d      = mask_q;
        acc_d       = acc_q;
        round_d     = round_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        misroute_d  = 1'b0;
        dup_d       = dup_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (!pkt_ok) begin
                        misroute_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = credit_pkt;
                        if (is_dup) begin
                            dup_d = 1'b1;
                        end else begin
                            mask_d = mask_q | src_slot;
                            acc_d  = acc_q + SUM_WIDTH'(in_psum);
                        end
                    end
                end
            end
            ST_ACK: begin
                if (out_fire) begin
                    if (mask_full) begin
                        out_data_d = result_pkt;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            ST_RESULT: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    mask_d      = '0;
                    acc_d       = '0;
                    round_d     = (round_q == 5'(ROUNDS_PER_ROW - 1)) ? 5'd0 : round_q + 5'd1;
                end
            end
            default: ;
        endcase
    end

    assign pkt_out_data  = out_data_q;
    assign pkt_out_valid = out_valid_q;
    assign err_misroute  = misroute_q;
    assign err_dup       = dup_q;
    assign round_idx     = round_q;

endmodule
